// File: rtl/pmodmic3_pkg.sv
// Shared types and constants for the PmodMIC3 sampler.
// Build option PMODMIC3_TWOS_COMP_EN: deliver samples as two's complement instead of offset binary.
package pmodmic3_pkg;

  typedef enum logic [2:0] {IDLE, DUMMY, WAIT_TICK, CONVERT, QUIET} state_e;

  localparam int FRAME_BITS = 16;
  localparam int DATA_BITS  = 12;
  localparam logic [DATA_BITS-1:0] MID_SCALE = 12'h800;

  // ADC result is offset binary; optionally re-centre it around zero.
  function automatic logic [DATA_BITS-1:0] fmt_sample(input logic [DATA_BITS-1:0] raw);
`ifdef PMODMIC3_TWOS_COMP_EN
    return raw - MID_SCALE;
`else
    return raw;
`endif
  endfunction

endpackage

// File: rtl/pmodmic3_sampler_if.sv
// Sample delivery handshake between the sampler and downstream capture logic.
interface pmodmic3_sampler_if;
  import pmodmic3_pkg::*;

  logic [DATA_BITS-1:0] sample_data;
  logic                 sample_valid;
  logic                 sample_ready;

  modport master (output sample_data, output sample_valid, input  sample_ready);
  modport slave  (input  sample_data, input  sample_valid, output sample_ready);
endinterface

// File: rtl/pmodmic3_spi_frame.sv
// One 16-bit ADC frame: CS_N low for 16*CLK_DIV cycles, registered SCLK, MSB-first capture.
module pmodmic3_spi_frame
  import pmodmic3_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sdata,
  output logic                  cs_n,
  output logic                  sclk,
  output logic                  done,
  output logic [FRAME_BITS-1:0] word
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] P_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] P_HALF = PW'(CLK_DIV / 2);
  localparam logic [3:0]    B_LAST = 4'(FRAME_BITS - 1);

  logic                  active_q, active_d;
  logic [PW-1:0]         p_q, p_d;
  logic [3:0]            bit_q, bit_d;
  logic                  cs_n_q, cs_n_d;
  logic                  sclk_q, sclk_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;

  // Combinational so the parent can act on the same edge CS_N rises.
  assign done = active_q && (p_q == P_LAST) && (bit_q == B_LAST);

  always_comb begin
    active_d = active_q;
    p_d      = p_q;
    bit_d    = bit_q;
    cs_n_d   = cs_n_q;
    sclk_d   = sclk_q;
    shift_d  = shift_q;
    if (!active_q) begin
      if (start) begin
        active_d = 1'b1;
        p_d      = '0;
        bit_d    = '0;
        cs_n_d   = 1'b0;
        sclk_d   = 1'b0;
        shift_d  = '0;
      end
    end else if (done) begin
      active_d = 1'b0;
      cs_n_d   = 1'b1;
      sclk_d   = 1'b1;
    end else begin
      p_d = (p_q == P_LAST) ? '0 : p_q + 1'b1;
      if (p_q == P_LAST) bit_d = bit_q + 1'b1;
      sclk_d = (p_d >= P_HALF);
      if (!sclk_q && sclk_d) shift_d = {shift_q[FRAME_BITS-2:0], sdata};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      p_q      <= '0;
      bit_q    <= '0;
      cs_n_q   <= 1'b1;
      sclk_q   <= 1'b1;
      shift_q  <= '0;
    end else begin
      active_q <= active_d;
      p_q      <= p_d;
      bit_q    <= bit_d;
      cs_n_q   <= cs_n_d;
      sclk_q   <= sclk_d;
      shift_q  <= shift_d;
    end
  end

  assign cs_n = cs_n_q;
  assign sclk = sclk_q;
  assign word = shift_q;

endmodule

// File: rtl/pmodmic3_sampler.sv
// PmodMIC3 conversion scheduler: sample-rate tick, power-up dummy frame, valid/ready delivery, sticky status.
// Build option PMODMIC3_TWOS_COMP_EN selects two's complement output (see pmodmic3_pkg::fmt_sample).
module pmodmic3_sampler
  import pmodmic3_pkg::*;
#(
  parameter int CLK_DIV    = 8,
  parameter int SAMPLE_DIV = 2500,
  parameter int QUIET_CYC  = 6
) (
  input  logic                      sysclk,
  input  logic                      sysrst_n,
  input  logic                      enable,
  output logic                      spi_cs_n,
  output logic                      spi_sclk,
  input  logic                      spi_sdata,
  pmodmic3_sampler_if.master        smp,
  output logic                      busy,
  output logic                      overrun,
  output logic                      late,
  output logic                      frame_err,
  input  logic                      clr_status
);

  localparam int CW = $clog2(SAMPLE_DIV);
  localparam int QW = $clog2(QUIET_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_DIV - 1);
  localparam logic [QW-1:0] QUI_LAST = QW'(QUIET_CYC - 1);

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [QW-1:0]          qcnt_q, qcnt_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ovr_q, ovr_d;
  logic                   late_q, late_d;
  logic                   ferr_q, ferr_d;

  logic                   tick, start, frame_done;
  logic [FRAME_BITS-1:0]  word;

  assign tick  = enable && (cnt_q == CNT_LAST);
  assign start = ((state_q == IDLE) && enable) || ((state_q == WAIT_TICK) && tick);

  pmodmic3_spi_frame #(.CLK_DIV(CLK_DIV)) u_frame (
    .clk   (sysclk),
    .rst_n (sysrst_n),
    .start (start),
    .sdata (spi_sdata),
    .cs_n  (spi_cs_n),
    .sclk  (spi_sclk),
    .done  (frame_done),
    .word  (word)
  );

  always_comb begin
    state_d = state_q;
    qcnt_d  = qcnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    late_d  = late_q;
    ferr_d  = ferr_q;
    cnt_d   = (!enable || tick) ? '0 : cnt_q + 1'b1;

    // Clear first so a same-edge set event below wins.
    if (clr_status) begin
      ovr_d  = 1'b0;
      late_d = 1'b0;
      ferr_d = 1'b0;
    end
    if (valid_q && smp.sample_ready) valid_d = 1'b0;

    case (state_q)
      IDLE:      if (enable) state_d = DUMMY;
      DUMMY:     if (frame_done) begin
                   state_d = QUIET;
                   qcnt_d  = '0;
                 end
      WAIT_TICK: if (tick)         state_d = CONVERT;
                 else if (!enable) state_d = IDLE;
      CONVERT:   if (frame_done) begin
                   state_d = QUIET;
                   qcnt_d  = '0;
                   if (valid_q && !smp.sample_ready) begin
                     ovr_d = 1'b1;
                   end else begin
                     data_d  = fmt_sample(word[DATA_BITS-1:0]);
                     valid_d = 1'b1;
                   end
                   if (word[FRAME_BITS-1:DATA_BITS] != '0) ferr_d = 1'b1;
                 end
      QUIET:     if (qcnt_q == QUI_LAST) state_d = enable ? WAIT_TICK : IDLE;
                 else                    qcnt_d  = qcnt_q + 1'b1;
      default:   state_d = IDLE;
    endcase

    // A tick outside WAIT_TICK is dropped, not queued.
    if (tick && (state_q != WAIT_TICK)) late_d = 1'b1;
  end

  always_ff @(posedge sysclk or negedge sysrst_n) begin
    if (!sysrst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      qcnt_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      late_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      qcnt_q  <= qcnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      late_q  <= late_d;
      ferr_q  <= ferr_d;
    end
  end

  assign smp.sample_data  = data_q;
  assign smp.sample_valid = valid_q;
  assign busy             = ~spi_cs_n;
  assign overrun          = ovr_q;
  assign late             = late_q;
  assign frame_err        = ferr_q;

endmodule

// File: tb/tb_pmodmic3_sampler.sv
// Scoreboarded bench: ADC word model, directed frames, monitor pops expected samples on valid&ready.
module tb_pmodmic3_sampler;
  import pmodmic3_pkg::*;

  logic clk = 1'b0, rst_n = 1'b0, en1 = 1'b0, en2 = 1'b0, clr = 1'b0;
  logic cs1, sclk1, busy1, ovr1, late1, ferr1, sdata1;
  logic cs2, sclk2, busy2, ovr2, late2, ferr2;
  logic [15:0] adc_word = 16'h0A5C;
  logic [15:0] adc_sh   = 16'h0000;
  logic [11:0] exp_q[$];
  int cnt = 0, errs = 0, cyc = 0;

  pmodmic3_sampler_if s1();
  pmodmic3_sampler_if s2();
  assign s2.sample_ready = 1'b1;

  pmodmic3_sampler #(.CLK_DIV(4), .SAMPLE_DIV(100), .QUIET_CYC(6)) dut1 (
    .sysclk(clk), .sysrst_n(rst_n), .enable(en1), .spi_cs_n(cs1), .spi_sclk(sclk1),
    .spi_sdata(sdata1), .smp(s1), .busy(busy1), .overrun(ovr1), .late(late1),
    .frame_err(ferr1), .clr_status(clr));

  pmodmic3_sampler #(.CLK_DIV(4), .SAMPLE_DIV(60), .QUIET_CYC(6)) dut2 (
    .sysclk(clk), .sysrst_n(rst_n), .enable(en2), .spi_cs_n(cs2), .spi_sclk(sclk2),
    .spi_sdata(1'b0), .smp(s2), .busy(busy2), .overrun(ovr2), .late(late2),
    .frame_err(ferr2), .clr_status(1'b0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ADC model: word latched at CS_N fall, next bit presented after each SCLK rise.
  always @(negedge cs1) adc_sh = adc_word;
  always @(posedge sclk1) if (!cs1) adc_sh = {adc_sh[14:0], 1'b0};
  assign sdata1 = adc_sh[15];

  function automatic logic [11:0] exp_of(input logic [11:0] raw);
`ifdef PMODMIC3_TWOS_COMP_EN
    return raw - 12'h800;
`else
    return raw;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    cnt++;
    if (act !== want) begin
      errs++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (s1.sample_valid && s1.sample_ready) begin
      cnt++;
      if (exp_q.size() == 0) begin
        errs++;
        $display("FAIL sample_unexpected: got %0h, want none", s1.sample_data);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        if (s1.sample_data !== e) begin
          errs++;
          $display("FAIL sample_data: got %0h, want %0h", s1.sample_data, e);
        end
      end
    end
  end

  task automatic wait_cs(input bit d2, input logic lvl, input int lim, output int t, output bit ok);
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < lim; i++) begin
      @(posedge clk); #1;
      if ((d2 ? cs2 : cs1) == lvl) begin
        ok = 1'b1;
        t  = cyc;
        break;
      end
    end
  endtask

  task automatic need(input bit d2, input logic lvl, output int t);
    bit ok;
    wait_cs(d2, lvl, 300, t, ok);
    check(lvl ? "wait_cs_rise" : "wait_cs_fall", 32'(ok), 32'd1);
  endtask

  initial begin
    int tf0, tr0, tf1, tr1, tf, tr, t;
    bit ok;
    s1.sample_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n",  32'(cs1), 32'd1);
    check("rst_sclk",  32'(sclk1), 32'd1);
    check("rst_data",  32'(s1.sample_data), 32'd0);
    check("rst_valid", 32'(s1.sample_valid), 32'd0);
    check("rst_busy",  32'(busy1), 32'd0);
    check("rst_ovr",   32'(ovr1), 32'd0);
    check("rst_late",  32'(late1), 32'd0);
    check("rst_ferr",  32'(ferr1), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Dummy frame discarded, first real sample delivered for one cycle.
    en1 = 1'b1;
    need(0, 1'b0, tf0);
    check("busy_in_frame", 32'(busy1), 32'd1);
    need(0, 1'b1, tr0);
    check("dummy_len", 32'(tr0 - tf0), 32'd64);
    check("dummy_discard", 32'(s1.sample_valid), 32'd0);
    exp_q.push_back(exp_of(12'hA5C));
    need(0, 1'b0, tf1);
    need(0, 1'b1, tr1);
    check("frame_len", 32'(tr1 - tf1), 32'd64);
    check("valid_set", 32'(s1.sample_valid), 32'd1);
    check("data_a5c", 32'(s1.sample_data), 32'(exp_of(12'hA5C)));
    @(posedge clk); #1;
    check("valid_one_cycle", 32'(s1.sample_valid), 32'd0);

    // Consumer stalls: first sample held, later ones dropped with overrun.
    s1.sample_ready = 1'b0;
    adc_word = 16'h0111;
    exp_q.push_back(exp_of(12'h111));
    need(0, 1'b0, tf);
    check("tick_spacing", 32'(tf - tf1), 32'd100);
    need(0, 1'b1, tr);
    check("held_valid", 32'(s1.sample_valid), 32'd1);
    check("held_data", 32'(s1.sample_data), 32'(exp_of(12'h111)));
    check("ovr_not_yet", 32'(ovr1), 32'd0);
    adc_word = 16'h0222;
    need(0, 1'b0, tf);
    need(0, 1'b1, tr);
    check("ovr_set", 32'(ovr1), 32'd1);
    check("held_data2", 32'(s1.sample_data), 32'(exp_of(12'h111)));
    adc_word = 16'h0333;
    need(0, 1'b0, tf);
    need(0, 1'b1, tr);
    check("held_data3", 32'(s1.sample_data), 32'(exp_of(12'h111)));
    adc_word = 16'hF123;
    exp_q.push_back(exp_of(12'h123));
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check("ovr_cleared", 32'(ovr1), 32'd0);
    s1.sample_ready = 1'b1;

    // Nonzero leading nibble flags frame_err.
    need(0, 1'b0, tf);
    check("ferr_before", 32'(ferr1), 32'd0);
    need(0, 1'b1, tr);
    check("ferr_set", 32'(ferr1), 32'd1);
    check("data_123", 32'(s1.sample_data), 32'(exp_of(12'h123)));

    // Enable drop mid-frame: frame finishes, sample delivered, then idle.
    adc_word = 16'h0456;
    exp_q.push_back(exp_of(12'h456));
    need(0, 1'b0, tf);
    repeat (19) @(posedge clk);
    #1;
    en1 = 1'b0;
    need(0, 1'b1, tr);
    check("drop_frame_len", 32'(tr - tf), 32'd64);
    wait_cs(0, 1'b0, 150, t, ok);
    check("idle_after_drop", 32'(ok), 32'd0);
    check("idle_busy", 32'(busy1), 32'd0);

    // Re-enable repeats the dummy frame before the next sample.
    adc_word = 16'h0789;
    en1 = 1'b1;
    need(0, 1'b0, tf);
    need(0, 1'b1, tr);
    check("redummy_discard", 32'(s1.sample_valid), 32'd0);
    adc_word = 16'h0000;
    exp_q.push_back(exp_of(12'h000));
    need(0, 1'b0, tf);
    need(0, 1'b1, tr);
    check("data_zero", 32'(s1.sample_data), 32'(exp_of(12'h000)));
    check("late_clean", 32'(late1), 32'd0);
    en1 = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // Sample period shorter than a frame: ticks land mid-frame.
    en2 = 1'b1;
    need(1, 1'b0, tf);
    need(1, 1'b1, tr);
    need(1, 1'b0, tf0);
    need(1, 1'b1, tr);
    need(1, 1'b0, tf1);
    check("late_spacing", 32'(tf1 - tf0), 32'd120);
    check("late_set", 32'(late2), 32'd1);
    repeat (10) @(posedge clk);
    #1;
    check("mid_frame_cs", 32'(cs2), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_cs", 32'(cs2), 32'd1);
    check("async_rst_sclk", 32'(sclk2), 32'd1);
    check("async_rst_late", 32'(late2), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt, errs);
    $finish;
  end

endmodule
